// File: rtl/riscv_pkg.sv
// Shared definitions for the mini RISC-V core: widths, reset PC, NOP encoding,
// the fetch state encoding and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    localparam int FETCH_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with single-cycle flush.
// The caller guarantees it never pushes into a full FIFO without popping.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             push,
    input  fetch_entry_t                     push_data,
    input  logic                             pop,
    output fetch_entry_t                     head,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign head   = mem_q[rd_q];
    assign do_pop = pop && !empty;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: the storage is reset because inst/inst_pc must read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads, buffers returns and hands {inst, inst_pc} to decode.
// Optional misaligned-redirect trap (fetch_fault/fault_pc, HALT state) under IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = FETCH_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [XLEN-1:0]  tag_q [2];
    logic [XLEN-1:0]  tag_d [2];
    logic             tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    fetch_entry_t     fifo_head, fifo_in;
    logic             fifo_full, fifo_empty, fifo_push;
    logic [CNT_W-1:0] fifo_count;
    logic             pop_fire, req_fire, fetching;
    logic [SUM_W-1:0] credit_used;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic             fault_q, fault_d;
    logic [XLEN-1:0]  fault_pc_q, fault_pc_d;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
`endif

    assign inst_valid = !fifo_empty && !redirect_valid;
    assign pop_fire   = inst_valid && inst_ready;
    assign fetching   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // The slot freed by this cycle's pop counts as credit, which sustains one fetch per cycle.
    assign credit_used = SUM_W'(outstanding_q) + SUM_W'(fifo_count) + SUM_W'(drop_q)
                       - SUM_W'(pop_fire);
    assign imem_req_valid = fetching && (credit_used < SUM_W'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc_q;

    assign fifo_in   = '{pc: tag_q[tag_rd_q], inst: imem_rsp_data};
    assign fifo_push = imem_rsp_valid && (drop_q == '0) && (!fifo_full || pop_fire);

    assign inst    = fifo_head.inst;
    assign inst_pc = fifo_head.pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (pop_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        tag_d         = tag_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
`endif
        if (req_fire) begin
            pc_d            = pc_q + 32'd4;
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = !tag_wr_q;
        end
        if (imem_rsp_valid) begin
            tag_rd_d = !tag_rd_q;
            if (drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:           state_d = ST_RUN;
            ST_RUN, ST_DRAIN:  state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            default:           state_d = state_q;
        endcase

        // Everything still in flight after this edge, including a request taken now, is stale.
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            drop_d = outstanding_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                fault_d = 1'b0;
                state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
            end
`else
            state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_q         <= '{default: '0};
            tag_wr_q      <= 1'b0;
            tag_rd_q      <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            tag_q         <= tag_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order memory model with 1-cycle latency (data = addr + 0x1000_0013)
// and hand-computed expectations checked by immediate assertions.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
`endif

    int          n_cmp;
    int          n_fail;
    int          n_req;
    bit          rsp_en;
    logic [31:0] pend [$];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr + 32'h1000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record a handshake, cross the edge, then drive the memory response and end any redirect pulse.
    task automatic cycle();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_addr);
            n_req++;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic wait_inst(input int budget);
        int n;
        n = 0;
        while (!inst_valid && n < budget) begin
            cycle();
            n++;
        end
        check("wait_inst_valid", {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        pend.delete();
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_req = 0;
        #1;
        check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        n_req          = 0;
        rsp_en         = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_pc    = '0;

        // Streaming from reset: request at cycle 2, first instruction at cycle 4, then one per cycle.
        do_reset();
        cycle();
        check("c2_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("c2_addr", imem_addr, 32'h0000_0000);
        cycle();
        check("c3_addr", imem_addr, 32'h0000_0004);
        check("c3_inst_valid", {31'b0, inst_valid}, 32'd0);
        cycle();
        check("c4_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("c4_inst_pc", inst_pc, 32'h0000_0000);
        check("c4_inst", inst, 32'h1000_0013);
        cycle();
        check("c5_inst_pc", inst_pc, 32'h0000_0004);
        check("c5_inst_valid", {31'b0, inst_valid}, 32'd1);
        cycle();
        check("c6_inst_pc", inst_pc, 32'h0000_0008);
        check("c6_inst", inst, 32'h1000_001B);

        // Mid-operation reset, then decode stalled: only two requests fit, head stays at 0x0.
        inst_ready = 1'b0;
        do_reset();
        repeat (6) cycle();
        check("stall_head_pc_early", inst_pc, 32'h0000_0000);
        repeat (6) cycle();
        check("stall_req_count", n_req, 32'd2);
        check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_inst_pc", inst_pc, 32'h0000_0000);
        inst_ready = 1'b1;
        #1;
        check("release_inst", inst, 32'h1000_0013);
        cycle();
        check("release_pc1", inst_pc, 32'h0000_0004);
        cycle();
        check("release_pc2", inst_pc, 32'h0000_0008);

        // Two requests outstanding when redirecting to 0x100: both responses are dropped.
        rsp_en = 1'b0;
        repeat (4) cycle();
        check("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("hold_inst_valid", {31'b0, inst_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
        rsp_en = 1'b1;
        wait_inst(12);
        check("redir_inst_pc", inst_pc, 32'h0000_0100);
        check("redir_inst", inst, 32'h1000_0113);

        // Redirect while a pop is possible and a request is handshaken: both are stale.
        do_reset();
        cycle();
        check("t4_req_addr0", imem_addr, 32'h0000_0000);
        cycle();
        imem_req_ready = 1'b0;
        cycle();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1;
        check("t4_pop_gated", {31'b0, inst_valid}, 32'd0);
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t4_req_addr", imem_addr, 32'h0000_0004);
        cycle();
        wait_inst(12);
        check("t4_inst_pc", inst_pc, 32'h0000_0300);
        check("t4_inst", inst, 32'h1000_0313);

        // PC wrap across the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        check("wrap_gate", {31'b0, inst_valid}, 32'd0);
        cycle();
        wait_inst(12);
        check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
        check("wrap_inst0", inst, 32'h1000_000B);
        cycle();
        check("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst1", inst, 32'h1000_000F);
        cycle();
        check("wrap_pc2", inst_pc, 32'h0000_0000);
        check("wrap_inst2", inst, 32'h1000_0013);

`ifdef IFETCH_MISALIGN_TRAP_EN
        // Misaligned target halts fetch; an aligned redirect resumes it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        cycle();
        check("trap_fault", {31'b0, fetch_fault}, 32'd1);
        check("trap_fault_pc", fault_pc, 32'h0000_0102);
        check("trap_no_req", {31'b0, imem_req_valid}, 32'd0);
        n_req = 0;
        repeat (5) cycle();
        check("trap_req_count", n_req, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cycle();
        check("trap_cleared", {31'b0, fetch_fault}, 32'd0);
        wait_inst(12);
        check("trap_resume_pc", inst_pc, 32'h0000_0200);
        check("trap_resume_inst", inst, 32'h1000_0213);
`else
        // Low target bits are ignored without the trap feature.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0401;
        cycle();
        check("align_addr", imem_addr, 32'h0000_0400);
        wait_inst(12);
        check("align_inst_pc", inst_pc, 32'h0000_0400);
        check("align_inst", inst, 32'h1000_0413);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the mini RISC-V core. Owns the program counter, issues word reads to instruction memory, buffers up to two returned words, and hands `{inst, inst_pc}` to the decode stage's field parser over a valid/ready handshake. Taken branches and jumps from execute redirect the PC, flush buffered words and discard in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `DEPTH`, default 2, buffer entries and maximum outstanding requests (fixed at 2; other values unsupported).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  word-aligned fetch address; bits [1:0] always 0.
- `imem_rsp_valid`  in  1  read data valid; responses return in request order, never stalled.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle PC redirect pulse from execute.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  `inst`/`inst_pc` valid to decode.
- `inst_ready`  in  1  decode accepts.
- `inst`  out  32  instruction word (feeds the field parser).
- `inst_pc`  out  32  address of `inst`.

## Operation
- States: IDLE (the one cycle after reset release), RUN, DRAIN (stale responses pending). IDLE->RUN unconditionally. RUN->DRAIN on redirect with stale responses > 0. DRAIN->RUN when the drop counter reaches 0.
- Request rule: `imem_req_valid` = state is RUN or DRAIN, and `outstanding + fifo_count + drop_cnt < DEPTH`, so every response has a buffer slot. On `imem_req_valid & imem_req_ready`: `pc <= pc + 4` (32-bit wrap, 0xFFFF_FFFC -> 0), `outstanding++`.
- Response: `outstanding--`. If `drop_cnt > 0`: `drop_cnt--` and the data is discarded. Otherwise the entry `{data, pc_of_request}` is pushed; request PCs are held in a 2-entry in-order tag queue.
- Output: `inst_valid` = FIFO not empty and no `redirect_valid` this cycle. Pop on `inst_valid & inst_ready`.
- Redirect, at the edge:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO flushed.
  - `drop_cnt` <= outstanding after this cycle's accepted request and arrived response are accounted.
  - Redirect overrides any pop in the same cycle.
- A request handshaken in the redirect cycle used the old PC and is counted stale.
- Push and pop in the same cycle with a full FIFO is legal; the count is unchanged.
- Reset, including mid-operation: `pc=RESET_PC`, state IDLE, counters 0, FIFO empty. `imem_req_valid=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `imem_addr=RESET_PC`. Responses to pre-reset requests are a system error; memory is reset with the core.

## Timing
- Reset release: edge 1 IDLE; first request asserted in cycle 2 at `RESET_PC`.
- Response at cycle N -> `inst_valid` in cycle N+1 (registered buffer); no combinational path from `imem_rsp_*` to `inst_*`.
- Redirect at cycle N -> request for the target in cycle N+1 if credit allows.
- Sustained throughput is 1 instruction/cycle with 1-cycle memory latency and `inst_ready` held high.
- `imem_req_valid` may deassert without a handshake; `imem_addr` is stable while `imem_req_valid & !imem_req_ready`, except across a redirect.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - Adds outputs `fetch_fault` (1 bit) and `fault_pc` (32 bits), both reset 0.
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_fault=1`, `fault_pc=redirect_pc`, enters HALT, and issues no requests.
  - In HALT the FIFO and drop handling proceed normally.
  - Only an aligned redirect clears the fault and returns to RUN or DRAIN.
- Not defined: the ports and HALT do not exist, and the low two target bits are silently cleared.

## Structure
- Shared package `riscv_pkg`: `XLEN=32`, `ILEN=32`, default `RESET_PC`, `NOP=32'h0000_0013`, and the fetch state enum (IDLE/RUN/DRAIN/HALT).
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO with flush, 64-bit entries `{pc, inst}`, full/empty flags and count.

## Test plan
- Reset release, memory ready with 1-cycle latency, `inst_ready=1` -> requests at 0x0, 0x4, 0x8… from cycle 2. First `inst_valid` in cycle 4 with `inst_pc=0`, then one instruction per cycle.
- Hold `inst_ready=0` for 10 cycles -> exactly 2 requests issued, `inst_valid` held with `inst_pc=0` stable. Release -> 0x0 then 0x4, no loss.
- Redirect to 0x100 with 2 requests outstanding -> the next 2 responses are dropped, the FIFO is flushed, and the next `inst_pc=0x100`.
- Redirect in the same cycle as a pop and a request handshake -> that pop is ignored, the request is treated as stale, and the next delivered `inst_pc` is the target.
- PC 0xFFFF_FFF8 sequence -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With `IFETCH_MISALIGN_TRAP_EN`, redirect to 0x102 -> `fetch_fault=1`, `fault_pc=0x102`, no requests. A later redirect to 0x200 -> fault cleared and fetch resumes at 0x200.
